// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches, buffers in-order
// responses with their PCs, and handles redirect flush and out-of-text faults.
module fetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] TEXT_START = 32'h0040_0000,
    parameter int unsigned TEXT_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] TEXT_LAST = TEXT_START + 32'(TEXT_BYTES) - 32'd4;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_r;
    logic          halted_r;
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [31:0]   pc_q_r    [DEPTH];
    logic [31:0]   instr_q_r [DEPTH];
    logic          fault_q_r [DEPTH];

    logic          in_range_s;
    logic          credit_s;
    logic          req_valid_s;
    logic          req_fire_s;
    logic          resp_push_s;
    logic          resp_drop_s;
    logic          fault_push_s;
    logic          push_s;
    logic          pop_s;
    logic [CW:0]   inflight_s;

    // Control strobes derived from registered state and this cycle's inputs.
    always_comb begin
        in_range_s   = (fetch_pc_r[1:0] == 2'b00) && (fetch_pc_r >= TEXT_START)
                       && (fetch_pc_r <= TEXT_LAST);
        inflight_s   = {1'b0, count_r} + {1'b0, outstanding_r};
        credit_s     = inflight_s < {1'b0, DEPTH_C};
        req_valid_s  = !rst && !halted_r && in_range_s && !redirect_valid && credit_s;
        req_fire_s   = req_valid_s && mem_req_ready;
        resp_drop_s  = mem_resp_valid && (drop_r != {CW{1'b0}});
        resp_push_s  = mem_resp_valid && (drop_r == {CW{1'b0}}) && !redirect_valid;
        // Fault waits for the pipe to drain so it lands after every older fetch.
        fault_push_s = !halted_r && !in_range_s && (outstanding_r == {CW{1'b0}})
                       && (count_r < DEPTH_C) && !redirect_valid;
        push_s       = resp_push_s || fault_push_s;
        pop_s        = (count_r != {CW{1'b0}}) && out_ready && !redirect_valid;
    end

    // Fetch/response pointers, credit counters and halt state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= TEXT_START;
            resp_pc_r     <= TEXT_START;
            count_r       <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            drop_r        <= {CW{1'b0}};
            halted_r      <= 1'b0;
            head_r        <= {AW{1'b0}};
            tail_r        <= {AW{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r    <= redirect_pc;
            resp_pc_r     <= redirect_pc;
            count_r       <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            drop_r        <= drop_r + outstanding_r - {{(CW-1){1'b0}}, mem_resp_valid};
            halted_r      <= 1'b0;
            head_r        <= {AW{1'b0}};
            tail_r        <= {AW{1'b0}};
        end else begin
            if (req_fire_s) fetch_pc_r <= fetch_pc_r + 32'd4;
            if (resp_push_s) resp_pc_r <= resp_pc_r + 32'd4;
            if (resp_drop_s) drop_r <= drop_r - {{(CW-1){1'b0}}, 1'b1};
            if (fault_push_s) halted_r <= 1'b1;
            if (push_s) tail_r <= tail_r + AW'(1'b1);
            if (pop_s) head_r <= head_r + AW'(1'b1);
            case ({req_fire_s, resp_push_s})
                2'b10:   outstanding_r <= outstanding_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   outstanding_r <= outstanding_r - {{(CW-1){1'b0}}, 1'b1};
                default: outstanding_r <= outstanding_r;
            endcase
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q_r[i]    <= 32'h0;
                instr_q_r[i] <= 32'h0;
                fault_q_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            pc_q_r[tail_r]    <= resp_push_s ? resp_pc_r : fetch_pc_r;
            instr_q_r[tail_r] <= resp_push_s ? mem_resp_data : 32'h0;
            fault_q_r[tail_r] <= !resp_push_s;
        end else begin
            pc_q_r[tail_r]    <= pc_q_r[tail_r];
            instr_q_r[tail_r] <= instr_q_r[tail_r];
            fault_q_r[tail_r] <= fault_q_r[tail_r];
        end
    end

    assign mem_req_valid = req_valid_s;
    assign mem_req_addr  = fetch_pc_r;
    assign out_valid     = (count_r != {CW{1'b0}});
    assign out_pc        = pc_q_r[head_r];
    assign out_instr     = instr_q_r[head_r];
    assign out_fault     = fault_q_r[head_r];
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus memory-model
// sequences for redirect flush corner cases.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rd;
        logic        ordy, redir;
        logic [31:0] rpc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc, e_instr;
        logic        e_flt;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    int          cyc;
    int          mem_lat;

    fetch_queue #(.DEPTH(4), .TEXT_START(32'h0040_0000), .TEXT_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic rdy, logic rv, logic [31:0] rd, logic ordy,
                                logic redir, logic [31:0] rpc, logic e_rv, logic [31:0] e_addr,
                                logic e_ov, logic [31:0] e_pc, logic [31:0] e_instr, logic e_flt);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ordy = ordy; v.redir = redir;
        v.rpc = rpc; v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_flt = e_flt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // One cycle against the memory model; ready always 1, fixed latency.
    task automatic mstep(input logic ordy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        rst = 1'b0; mem_req_ready = 1'b1; out_ready = ordy;
        redirect_valid = redir; redirect_pc = rpc;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
        end
        #1;
        if (mem_req_valid && mem_req_ready) begin
            pend_addr.push_back(mem_req_addr);
            pend_due.push_back(cyc + mem_lat);
        end
        cyc++;
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rst = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
            out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        end
        pend_addr.delete();
        pend_due.delete();
        cyc = 0;
    endtask

    task automatic wait_head(input string name, input logic [31:0] e_pc, input logic [31:0] e_instr);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            mstep(1'b0, 1'b0, 32'h0);
            got = out_valid;
        end
        chk({name, ".timeout"}, {31'h0, got}, 32'h1);
        chk({name, ".pc"}, out_pc, e_pc);
        chk({name, ".instr"}, out_instr, e_instr);
        chk({name, ".fault"}, {31'h0, out_fault}, 32'h0);
    endtask

    initial begin
        //             rst  rdy  rv   rd             ordy redir rpc            e_rv e_addr         e_ov e_pc           e_instr        flt
        tbl[0]  = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0,        1'b0);
        tbl[1]  = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0040_0000,1'b0,32'h0,        32'h0,        1'b0);
        tbl[2]  = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1,32'h0040_0000,1'b0,32'h0,        32'h0,        1'b0);
        tbl[3]  = mk(1'b0,1'b1,1'b1,32'hC0DE_0000,1'b1,1'b0,32'h0,        1'b1,32'h0040_0004,1'b0,32'h0,        32'h0,        1'b0);
        tbl[4]  = mk(1'b0,1'b1,1'b1,32'hC0DE_0004,1'b1,1'b0,32'h0,        1'b1,32'h0040_0008,1'b1,32'h0040_0000,32'hC0DE_0000,1'b0);
        tbl[5]  = mk(1'b0,1'b1,1'b1,32'hC0DE_0008,1'b1,1'b0,32'h0,        1'b1,32'h0040_000C,1'b1,32'h0040_0004,32'hC0DE_0004,1'b0);
        tbl[6]  = mk(1'b0,1'b1,1'b1,32'hC0DE_000C,1'b1,1'b0,32'h0,        1'b1,32'h0040_0010,1'b1,32'h0040_0008,32'hC0DE_0008,1'b0);
        tbl[7]  = mk(1'b0,1'b1,1'b1,32'hC0DE_0010,1'b0,1'b0,32'h0,        1'b1,32'h0040_0014,1'b1,32'h0040_000C,32'hC0DE_000C,1'b0);
        tbl[8]  = mk(1'b0,1'b1,1'b1,32'hC0DE_0014,1'b0,1'b0,32'h0,        1'b1,32'h0040_0018,1'b1,32'h0040_000C,32'hC0DE_000C,1'b0);
        tbl[9]  = mk(1'b0,1'b1,1'b1,32'hC0DE_0018,1'b0,1'b0,32'h0,        1'b0,32'h0040_001C,1'b1,32'h0040_000C,32'hC0DE_000C,1'b0);
        tbl[10] = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0040_001C,1'b1,32'h0040_000C,32'hC0DE_000C,1'b0);
        tbl[11] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0040_001C,1'b1,32'h0040_000C,32'hC0DE_000C,1'b0);
        tbl[12] = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b1,32'h0040_001C,1'b1,32'h0040_0010,32'hC0DE_0010,1'b0);
        tbl[13] = mk(1'b0,1'b1,1'b1,32'hC0DE_001C,1'b0,1'b0,32'h0,        1'b0,32'h0040_0020,1'b1,32'h0040_0010,32'hC0DE_0010,1'b0);
        tbl[14] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h0040_03FC,1'b0,32'h0040_0020,1'b1,32'h0040_0010,32'hC0DE_0010,1'b0);
        tbl[15] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1,32'h0040_03FC,1'b0,32'h0,        32'h0,        1'b0);
        tbl[16] = mk(1'b0,1'b1,1'b1,32'hC0DE_03FC,1'b1,1'b0,32'h0,        1'b0,32'h0040_0400,1'b0,32'h0,        32'h0,        1'b0);
        tbl[17] = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0040_0400,1'b1,32'h0040_03FC,32'hC0DE_03FC,1'b0);
        tbl[18] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0040_0400,1'b1,32'h0040_03FC,32'hC0DE_03FC,1'b0);
        tbl[19] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0040_0400,1'b1,32'h0040_0400,32'h0,        1'b1);
        tbl[20] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0040_0400,1'b0,32'h0,        32'h0,        1'b0);
        tbl[21] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0040_0400,1'b0,32'h0,        32'h0,        1'b0);
        tbl[22] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h0040_0002,1'b0,32'h0040_0400,1'b0,32'h0,        32'h0,        1'b0);
        tbl[23] = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0040_0002,1'b0,32'h0,        32'h0,        1'b0);
        tbl[24] = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0040_0002,1'b1,32'h0040_0002,32'h0,        1'b1);
        tbl[25] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0040_0002,1'b1,32'h0040_0002,32'h0,        1'b1);
        tbl[26] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b0,32'h0040_0002,1'b0,32'h0,        32'h0,        1'b0);
        tbl[27] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0040_0000,1'b0,32'h0040_0002,1'b0,32'h0,        32'h0,        1'b0);
        tbl[28] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1,32'h0040_0000,1'b0,32'h0,        32'h0,        1'b0);
        tbl[29] = mk(1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,        1'b1,32'h0040_0000,1'b0,32'h0,        32'h0,        1'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; mem_req_ready = tbl[i].rdy; mem_resp_valid = tbl[i].rv;
            mem_resp_data = tbl[i].rd; out_ready = tbl[i].ordy;
            redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc;
            #1;
            if (i > 0) begin
                chk($sformatf("v%0d.req_valid", i), {31'h0, mem_req_valid}, {31'h0, tbl[i].e_rv});
                chk($sformatf("v%0d.req_addr", i), mem_req_addr, tbl[i].e_addr);
                chk($sformatf("v%0d.out_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].e_ov});
                if (tbl[i].e_ov || tbl[i].rst) begin
                    chk($sformatf("v%0d.out_pc", i), out_pc, tbl[i].e_pc);
                    chk($sformatf("v%0d.out_instr", i), out_instr, tbl[i].e_instr);
                    chk($sformatf("v%0d.out_fault", i), {31'h0, out_fault}, {31'h0, tbl[i].e_flt});
                end
            end
        end

        // 3-cycle memory, two fetches in flight, redirect discards both.
        mem_lat = 3;
        mreset();
        mstep(1'b0, 1'b0, 32'h0);
        chk("B.req0", mem_req_addr, 32'h0040_0000);
        mstep(1'b0, 1'b0, 32'h0);
        chk("B.req1", mem_req_addr, 32'h0040_0004);
        mstep(1'b0, 1'b1, 32'h0040_0100);
        chk("B.redir_noreq", {31'h0, mem_req_valid}, 32'h0);
        mstep(1'b0, 1'b0, 32'h0);
        chk("B.empty", {31'h0, out_valid}, 32'h0);
        chk("B.newreq_v", {31'h0, mem_req_valid}, 32'h1);
        chk("B.newreq_a", mem_req_addr, 32'h0040_0100);
        wait_head("B.first", 32'h0040_0100, 32'hC0DE_0100);

        // Redirect coinciding with a response and a consumer pop.
        mreset();
        for (int k = 0; k < 5; k++) mstep(1'b1, 1'b0, 32'h0);
        mstep(1'b1, 1'b1, 32'h0040_0200);
        chk("C.head_before", out_pc, 32'h0040_0004);
        chk("C.resp_same_cycle", {31'h0, mem_resp_valid}, 32'h1);
        chk("C.redir_noreq", {31'h0, mem_req_valid}, 32'h0);
        mstep(1'b0, 1'b0, 32'h0);
        chk("C.empty", {31'h0, out_valid}, 32'h0);
        chk("C.newreq_a", mem_req_addr, 32'h0040_0200);
        wait_head("C.first", 32'h0040_0200, 32'hC0DE_0200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
